// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: default phase-error width, phase-detector state encoding
// and the symmetric saturation magnitude helper used by the detector and loop filter.
package adpll_pkg;

   localparam int DEFAULT_ERROR_WIDTH = 8;

   typedef enum logic [1:0] {
      PD_IDLE     = 2'd0,
      PD_REF_LEAD = 2'd1,
      PD_FB_LEAD  = 2'd2
   } pd_state_t;

   // Largest magnitude representable symmetrically in a two's-complement word.
   function automatic int err_max(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

endpackage

// File: rtl/adpll_edge_sync.sv
// Two-flop synchroniser for an asynchronous clock-like input, followed by a registered
// rising-edge detector. The pulse appears 3 gen_clk_i edges after the pin edge is captured.
module adpll_edge_sync (
   input  logic gen_clk_i,
   input  logic reset_i,
   input  logic async_i,
   output logic rise_o
);

   // [0],[1] are the synchroniser, [2] is the previous synchronised level.
   logic [2:0] sync_q;

   // NOTE: non-blocking assignments let every flop sample the pre-edge value, so the
   // shift chain advances exactly one stage per clock regardless of statement order.
   always_ff @(posedge gen_clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync_q <= '0;
         rise_o <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], async_i};
         rise_o <= sync_q[1] & ~sync_q[2];
      end
   end

endmodule

// File: rtl/adpll_phase_detector.sv
// Counter-based phase/frequency detector: counts gen_clk_i cycles between ref and fb
// rising edges, publishes a signed saturating error with a valid strobe, and tracks lock.
module adpll_phase_detector
   import adpll_pkg::*;
#(
   parameter int ERROR_WIDTH = DEFAULT_ERROR_WIDTH,
   parameter int LOCK_TOL    = 1,
   parameter int LOCK_COUNT  = 16
) (
   input  logic                          gen_clk_i,
   input  logic                          reset_i,
   input  logic                          ref_i,
   input  logic                          fb_i,
   output logic signed [ERROR_WIDTH-1:0] error_o,
   output logic                          error_valid_o,
   output logic                          lock_o
);

   localparam int CW = ERROR_WIDTH - 1;
   localparam int LW = $clog2(LOCK_COUNT + 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(err_max(ERROR_WIDTH));
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] TOL_MAG   = CW'(LOCK_TOL);
   localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_COUNT);

   logic ref_rise;
   logic fb_rise;

   adpll_edge_sync u_ref_sync (
      .gen_clk_i (gen_clk_i),
      .reset_i   (reset_i),
      .async_i   (ref_i),
      .rise_o    (ref_rise)
   );

   adpll_edge_sync u_fb_sync (
      .gen_clk_i (gen_clk_i),
      .reset_i   (reset_i),
      .async_i   (fb_i),
      .rise_o    (fb_rise)
   );

   pd_state_t               state;
   pd_state_t               state_nxt;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_nxt;
   logic [CW-1:0]           cnt_inc;
   logic                    pub;
   logic                    pub_neg;
   logic [CW-1:0]           pub_mag;
   logic [ERROR_WIDTH-1:0]  pub_val;
   logic [LW-1:0]           lock_cnt;
   logic [LW-1:0]           lock_cnt_nxt;

   assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;

   // NOTE: every signal driven here gets a default first, so no path through the case
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pub       = 1'b0;
      pub_neg   = 1'b0;
      pub_mag   = '0;
      unique case (state)
         PD_IDLE: begin
            if (ref_rise && fb_rise) begin
               pub = 1'b1;
            end else if (ref_rise) begin
               state_nxt = PD_REF_LEAD;
               cnt_nxt   = CNT_ONE;
            end else if (fb_rise) begin
               state_nxt = PD_FB_LEAD;
               cnt_nxt   = CNT_ONE;
            end
         end
         PD_REF_LEAD: begin
            if (fb_rise) begin
               pub       = 1'b1;
               pub_mag   = cnt;
               state_nxt = PD_IDLE;
               cnt_nxt   = '0;
            end else if (ref_rise) begin
               // Cycle slip: a second ref edge before any fb edge.
               pub     = 1'b1;
               pub_mag = CNT_MAX;
               cnt_nxt = CNT_ONE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         PD_FB_LEAD: begin
            pub_neg = 1'b1;
            if (ref_rise) begin
               pub       = 1'b1;
               pub_mag   = cnt;
               state_nxt = PD_IDLE;
               cnt_nxt   = '0;
            end else if (fb_rise) begin
               pub     = 1'b1;
               pub_mag = CNT_MAX;
               cnt_nxt = CNT_ONE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = PD_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Magnitude never exceeds MAX, so the negated value is always representable.
   assign pub_val = pub_neg ? -{1'b0, pub_mag} : {1'b0, pub_mag};

   always_comb begin
      lock_cnt_nxt = '0;
      if (pub_mag <= TOL_MAG) begin
         lock_cnt_nxt = (lock_cnt == LOCK_FULL) ? LOCK_FULL : lock_cnt + LW'(1);
      end
   end

   always_ff @(posedge gen_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state         <= PD_IDLE;
         cnt           <= '0;
         error_o       <= '0;
         error_valid_o <= 1'b0;
         lock_cnt      <= '0;
         lock_o        <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         error_valid_o <= pub;
         if (pub) begin
            error_o  <= pub_val;
            lock_cnt <= lock_cnt_nxt;
            lock_o   <= (lock_cnt_nxt == LOCK_FULL);
         end
      end
   end

endmodule

// File: tb/tb_adpll_phase_detector.sv
// Directed bench for adpll_phase_detector: hand-computed errors, strobe timing,
// saturation, cycle slip, lock hysteresis and asynchronous reset mid-measurement.
module tb_adpll_phase_detector;

   localparam int EW = 8;

   logic          gen_clk_i = 1'b0;
   logic          reset_i;
   logic          ref_i;
   logic          fb_i;
   logic [EW-1:0] error_o;
   logic          error_valid_o;
   logic          lock_o;

   int total = 0;
   int bad   = 0;

   always #5 gen_clk_i = ~gen_clk_i;

   adpll_phase_detector #(
      .ERROR_WIDTH (EW),
      .LOCK_TOL    (1),
      .LOCK_COUNT  (4)
   ) dut (
      .gen_clk_i     (gen_clk_i),
      .reset_i       (reset_i),
      .ref_i         (ref_i),
      .fb_i          (fb_i),
      .error_o       (error_o),
      .error_valid_o (error_valid_o),
      .lock_o        (lock_o)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge gen_clk_i);
   endtask

   // Drives the edge pair for error e and stops on the negedge where valid is due.
   task automatic pair(input int e);
      if (e == 0) begin
         ref_i = 1'b1;
         fb_i  = 1'b1;
      end else if (e > 0) begin
         ref_i = 1'b1;
         tick(e);
         fb_i = 1'b1;
      end else begin
         fb_i = 1'b1;
         tick(-e);
         ref_i = 1'b1;
      end
      tick(4);
   endtask

   task automatic idle_gap;
      ref_i = 1'b0;
      fb_i  = 1'b0;
      tick(3);
   endtask

   task automatic test_reset;
      reset_i = 1'b1;
      ref_i   = 1'b0;
      fb_i    = 1'b0;
      tick(3);
      total++; if (error_o !== 8'h00) begin bad++; $display("FAIL reset_error: got %h want 00", error_o); end
      total++; if (error_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", error_valid_o); end
      total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL reset_lock: got %b want 0", lock_o); end
      reset_i = 1'b0;
      tick(2);
   endtask

   task automatic test_ref_lead;
      ref_i = 1'b1;
      tick(5);
      fb_i = 1'b1;
      tick(3);
      total++; if (error_valid_o !== 1'b0) begin bad++; $display("FAIL ref_lead_early_valid: got %b want 0", error_valid_o); end
      tick(1);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL ref_lead_valid: got %b want 1", error_valid_o); end
      total++; if (error_o !== 8'h05) begin bad++; $display("FAIL ref_lead_error: got %h want 05", error_o); end
      tick(1);
      total++; if (error_valid_o !== 1'b0) begin bad++; $display("FAIL ref_lead_pulse_width: got %b want 0", error_valid_o); end
      total++; if (error_o !== 8'h05) begin bad++; $display("FAIL ref_lead_hold: got %h want 05", error_o); end
      idle_gap();
   endtask

   task automatic test_fb_lead;
      fb_i = 1'b1;
      tick(3);
      ref_i = 1'b1;
      tick(4);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL fb_lead_valid: got %b want 1", error_valid_o); end
      total++; if (error_o !== 8'hFD) begin bad++; $display("FAIL fb_lead_error: got %h want fd", error_o); end
      tick(1);
      total++; if (error_valid_o !== 1'b0) begin bad++; $display("FAIL fb_lead_pulse_width: got %b want 0", error_valid_o); end
      total++; if (error_o !== 8'hFD) begin bad++; $display("FAIL fb_lead_hold: got %h want fd", error_o); end
      idle_gap();
   endtask

   task automatic test_same_cycle;
      int extra;
      error_valid_seen_reset: extra = 0;
      pair(0);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL same_valid: got %b want 1", error_valid_o); end
      total++; if (error_o !== 8'h00) begin bad++; $display("FAIL same_error: got %h want 00", error_o); end
      ref_i = 1'b0;
      fb_i  = 1'b0;
      repeat (6) begin
         tick(1);
         if (error_valid_o) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL same_extra_valid: got %0d want 0", extra); end
      // A stray lead state would corrupt this follow-up measurement.
      pair(2);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL same_followup_valid: got %b want 1", error_valid_o); end
      total++; if (error_o !== 8'h02) begin bad++; $display("FAIL same_followup_error: got %h want 02", error_o); end
      idle_gap();
   endtask

   task automatic test_slip;
      ref_i = 1'b1;
      tick(200);
      fb_i = 1'b1;
      tick(4);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL sat_valid: got %b want 1", error_valid_o); end
      total++; if (error_o !== 8'h7F) begin bad++; $display("FAIL sat_error: got %h want 7f", error_o); end
      idle_gap();
      ref_i = 1'b1;
      tick(3);
      ref_i = 1'b0;
      tick(3);
      ref_i = 1'b1;
      tick(4);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL slip_valid: got %b want 1", error_valid_o); end
      total++; if (error_o !== 8'h7F) begin bad++; $display("FAIL slip_error: got %h want 7f", error_o); end
      tick(3);
      fb_i = 1'b1;
      tick(4);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL slip_next_valid: got %b want 1", error_valid_o); end
      total++; if (error_o !== 8'h07) begin bad++; $display("FAIL slip_next_error: got %h want 07", error_o); end
      idle_gap();
   endtask

   task automatic test_lock;
      reset_i = 1'b1;
      tick(2);
      reset_i = 1'b0;
      tick(2);
      pair(0);
      total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL lock_after_1: got %b want 0", lock_o); end
      idle_gap();
      pair(1);
      total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL lock_after_2: got %b want 0", lock_o); end
      idle_gap();
      pair(-1);
      total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL lock_after_3: got %b want 0", lock_o); end
      total++; if (error_o !== 8'hFF) begin bad++; $display("FAIL lock_minus_one: got %h want ff", error_o); end
      idle_gap();
      pair(0);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL lock_4th_valid: got %b want 1", error_valid_o); end
      total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL lock_rise: got %b want 1", lock_o); end
      idle_gap();
      total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL lock_hold: got %b want 1", lock_o); end
      pair(5);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL unlock_valid: got %b want 1", error_valid_o); end
      total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL unlock_fall: got %b want 0", lock_o); end
      idle_gap();
      pair(0);
      idle_gap();
      pair(1);
      idle_gap();
      pair(0);
      total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL relock_short: got %b want 0", lock_o); end
      idle_gap();
   endtask

   task automatic test_reset_mid;
      repeat (4) begin
         pair(1);
         idle_gap();
      end
      total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL mid_prelock: got %b want 1", lock_o); end
      total++; if (error_o !== 8'h01) begin bad++; $display("FAIL mid_preerror: got %h want 01", error_o); end
      ref_i = 1'b1;
      tick(10);
      #3 reset_i = 1'b1;
      #1;
      total++; if (error_o !== 8'h00) begin bad++; $display("FAIL mid_async_error: got %h want 00", error_o); end
      total++; if (error_valid_o !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", error_valid_o); end
      total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL mid_async_lock: got %b want 0", lock_o); end
      ref_i = 1'b0;
      tick(3);
      reset_i = 1'b0;
      tick(3);
      fb_i = 1'b1;
      tick(2);
      ref_i = 1'b1;
      tick(4);
      total++; if (error_valid_o !== 1'b1) begin bad++; $display("FAIL mid_after_valid: got %b want 1", error_valid_o); end
      total++; if (error_o !== 8'hFE) begin bad++; $display("FAIL mid_after_error: got %h want fe", error_o); end
      idle_gap();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1;
      ref_i   = 1'b0;
      fb_i    = 1'b0;
      test_reset();
      test_ref_lead();
      test_fb_lead();
      test_same_cycle();
      test_slip();
      test_lock();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
